ram_arbiter: RTL and testbench

//  Two-port arbiter and access sequencer in front of one Ram instance (shared 8-bit tristate data bus).

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_if.sv | 16 +
 rtl/ram_arbiter_rr_arbiter2.sv | 25 ++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM state encoding and port ids.
// No logic; latency n/a.
// No backpressure; types only.
package ram_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: single-byte read/write request with ack pulse.
// Latency n/a (wires only).
// Requester holds req/we/addr/wdata stable until ack.
interface ram_arbiter_if #(
    parameter int AddrBits = 16
) ();
    logic                req;
    logic                we;
    logic [AddrBits-1:0] addr;
    logic [7:0]          wdata;
    logic                ack;
    logic [7:0]          rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin pick: on a tie the port that did not win last time wins.
// Zero latency.
// No backpressure; valid is simply "anyone eligible".
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_t last_grant,
    output port_t grant,
    output logic  valid
);

    // Single requester wins outright; a tie goes to the port opposite the last winner.
    always_comb begin
        grant = PORT_A;
        valid = req_a | req_b;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of one RAM with a shared tristate byte bus.
// Latency: req sampled at edge N, bus active cycle N+1, ack high cycle N+2.
// One access per two cycles; ports not granted simply wait with req held.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AddrBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    ram_arbiter_if.slave        porta,
    ram_arbiter_if.slave        portb,
    output logic                ramChipSelect,
    output logic                ramWrite,
    output logic [AddrBits-1:0] ramAddress,
    inout  wire  [7:0]          ramData
);

    state_t              state, state_nx;
    port_t               grant_q, last_grant;
    port_t               arb_grant;
    logic                arb_vld;
    logic                elig_a, elig_b;
    logic                ack_a, ack_b;
    logic [7:0]          rdata_a, rdata_b;
    logic [7:0]          wdata_q;
    logic                sel_we;
    logic [AddrBits-1:0] sel_addr;
    logic [7:0]          sel_wdata;

    // A port in its ack cycle is not eligible, so one ack never chains into a regrant.
    assign elig_a = porta.req & ~ack_a;
    assign elig_b = portb.req & ~ack_b;

    rr_arbiter2 u_rr (
        .req_a      (elig_a),
        .req_b      (elig_b),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_vld)
    );

    // Request fields of whichever port the arbiter picked.
    always_comb begin
        sel_we    = porta.we;
        sel_addr  = porta.addr;
        sel_wdata = porta.wdata;
        if (arb_grant == PORT_B) begin
            sel_we    = portb.we;
            sel_addr  = portb.addr;
            sel_wdata = portb.wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state: IDLE waits for an eligible port, ACCESS always lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (arb_vld) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Bus, grant, ack and read-data registers. A write on the bus during a reset edge still
    // commits in the RAM (it has no reset); here it just ends with no ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= PORT_A;
            last_grant    <= PORT_B;
            ramChipSelect <= 1'b0;
            ramWrite      <= 1'b0;
            ramAddress    <= '0;
            wdata_q       <= 8'h00;
            ack_a         <= 1'b0;
            ack_b         <= 1'b0;
            rdata_a       <= 8'h00;
            rdata_b       <= 8'h00;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_q       <= arb_grant;
                        last_grant    <= arb_grant;
                        ramChipSelect <= 1'b1;
                        ramWrite      <= sel_we;
                        ramAddress    <= sel_addr;
                        wdata_q       <= sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    ramChipSelect <= 1'b0;
                    ramWrite      <= 1'b0;
                    if (grant_q == PORT_A) begin
                        ack_a <= 1'b1;
                        if (!ramWrite) rdata_a <= ramData;
                    end else begin
                        ack_b <= 1'b1;
                        if (!ramWrite) rdata_b <= ramData;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only drive the shared bus while writing; the RAM drives it only on reads.
    assign ramData = ramWrite ? wdata_q : 8'bz;

    assign porta.ack   = ack_a;
    assign porta.rdata = rdata_a;
    assign portb.ack   = ack_b;
    assign portb.rdata = rdata_b;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural RAM on the tristate bus and a reference memory model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ramChipSelect, ramWrite;
    logic [15:0] ramAddress;
    wire  [7:0]  ramData;

    ram_arbiter_if #(.AddrBits(16)) pa ();
    ram_arbiter_if #(.AddrBits(16)) pb ();

    ram_arbiter #(.AddrBits(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .porta         (pa.slave),
        .portb         (pb.slave),
        .ramChipSelect (ramChipSelect),
        .ramWrite      (ramWrite),
        .ramAddress    (ramAddress),
        .ramData       (ramData)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: writes ignore chip select, reads drive the bus combinationally.
    logic [7:0] mem [0:65535];
    assign ramData = (ramChipSelect && !ramWrite) ? mem[ramAddress] : 8'bz;
    always @(posedge clk) begin
        if (ramWrite) mem[ramAddress] <= ramData;
    end

    // Reference model of RAM contents.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    int n_pass = 0;
    int n_total = 0;
    int ack_a_cnt = 0;
    int ack_b_cnt = 0;
    bit prev_ack_a = 0, prev_ack_b = 0;
    bit ackq [$];

    // Per-cycle invariants and ack logging.
    always @(negedge clk) begin
        n_total++;
        if (ramWrite && !ramChipSelect) $display("FAIL inv_we_cs: we=%0b cs=%0b, want we->cs", ramWrite, ramChipSelect);
        else if (pa.ack && pb.ack) $display("FAIL inv_two_acks: ackA=1 ackB=1, want at most one");
        else if (ramChipSelect && $isunknown(ramData)) $display("FAIL inv_bus_x: data=%h, want known", ramData);
        else if ((prev_ack_a && pa.ack) || (prev_ack_b && pb.ack)) $display("FAIL inv_ack_width: ack high 2 cycles, want 1");
        else n_pass++;
        prev_ack_a = pa.ack;
        prev_ack_b = pb.ack;
        if (pa.ack) begin ack_a_cnt++; ackq.push_back(1'b0); end
        if (pb.ack) begin ack_b_cnt++; ackq.push_back(1'b1); end
    end

    task automatic set_port(input bit p, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
        if (p) begin pb.req = r; pb.we = w; pb.addr = a; pb.wdata = d; end
        else   begin pa.req = r; pa.we = w; pa.addr = a; pa.wdata = d; end
    endtask

    // Issue one access and wait (bounded) for its ack; lat counts negedges from drive, 99 = timeout.
    task automatic do_port(input bit p, input bit w, input logic [15:0] a, input logic [7:0] d,
                           input bit hold, output logic [7:0] rd, output int lat);
        bit got = 0;
        set_port(p, 1'b1, w, a, d);
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = p ? pb.ack : pa.ack;
        end
        rd = p ? pb.rdata : pa.rdata;
        if (!got) lat = 99;
        if (!hold || !got) set_port(p, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if ({pa.ack, pb.ack} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {pa.ack, pb.ack}); else n_pass++;
        n_total++; if ({pa.rdata, pb.rdata} !== 16'h0) $display("FAIL reset_rdata: got %h want 0000", {pa.rdata, pb.rdata}); else n_pass++;
        n_total++; if ({ramChipSelect, ramWrite} !== 2'b00) $display("FAIL reset_cs_we: got %b want 00", {ramChipSelect, ramWrite}); else n_pass++;
        n_total++; if (ramAddress !== 16'h0) $display("FAIL reset_addr: got %h want 0000", ramAddress); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] rd; int lat; int b0;
        b0 = ack_b_cnt;
        @(posedge clk); #1;
        do_port(1'b0, 1'b1, 16'h1234, 8'hA5, 1'b0, rd, lat);
        ref_mem[16'h1234] = 8'hA5;
        n_total++; if (lat !== 3) $display("FAIL basic_wr_lat: got %0d want 3", lat); else n_pass++;
        @(posedge clk); #1;
        do_port(1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, rd, lat);
        n_total++; if (lat !== 3) $display("FAIL basic_rd_lat: got %0d want 3", lat); else n_pass++;
        n_total++; if (rd !== 8'hA5) $display("FAIL basic_rd_data: got %h want a5", rd); else n_pass++;
        n_total++; if (ack_b_cnt !== b0) $display("FAIL basic_no_ackb: got %0d want %0d", ack_b_cnt, b0); else n_pass++;
    endtask

    task automatic test_tie();
        logic [7:0] rda, rdb, exp_old; int la, lb;
        do_reset();
        exp_old = ref_rd(16'h0010);
        @(posedge clk); #1;
        fork
            do_port(1'b1, 1'b1, 16'h0010, 8'h3C, 1'b0, rdb, lb);
            do_port(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, rda, la);
        join
        ref_mem[16'h0010] = 8'h3C;
        n_total++; if (la !== 3) $display("FAIL tie_a_lat: got %0d want 3", la); else n_pass++;
        n_total++; if (lb !== 5) $display("FAIL tie_b_lat: got %0d want 5", lb); else n_pass++;
        n_total++; if (rda !== exp_old) $display("FAIL tie_a_old: got %h want %h", rda, exp_old); else n_pass++;
        @(posedge clk); #1;
        do_port(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, rda, la);
        n_total++; if (rda !== 8'h3C || la !== 3) $display("FAIL tie_a_new: got %h lat %0d want 3c lat 3", rda, la); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit         wa [4], wb [4];
        logic [15:0] aa [4], ab [4];
        logic [7:0] da [4], db [4], ra [4], rb [4], ex;
        int         to = 0;
        for (int k = 0; k < 4; k++) begin
            wa[k] = 1'($urandom_range(0, 1)); wb[k] = 1'($urandom_range(0, 1));
            aa[k] = 16'h0200 + 16'($urandom_range(0, 3)); ab[k] = 16'h0200 + 16'($urandom_range(0, 3));
            da[k] = 8'($urandom); db[k] = 8'($urandom);
        end
        do_reset();
        @(posedge clk); #1;
        ackq.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int l; logic [7:0] r;
                    do_port(1'b0, wa[k], aa[k], da[k], k < 3, r, l);
                    ra[k] = r; if (l == 99) to++;
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int l; logic [7:0] r;
                    do_port(1'b1, wb[k], ab[k], db[k], k < 3, r, l);
                    rb[k] = r; if (l == 99) to++;
                end
            end
        join
        repeat (2) @(negedge clk);
        n_total++; if (to !== 0) $display("FAIL b2b_timeout: got %0d timeouts want 0", to); else n_pass++;
        n_total++; if (ackq.size() !== 8) $display("FAIL b2b_count: got %0d acks want 8", ackq.size()); else n_pass++;
        for (int i = 0; i < 8 && i < ackq.size(); i++) begin
            n_total++;
            if (ackq[i] !== 1'(i % 2)) $display("FAIL b2b_order[%0d]: got port %0d want %0d", i, ackq[i], i % 2);
            else n_pass++;
        end
        // Replay in the alternating A,B,A,B grant order to get the expected read data.
        for (int k = 0; k < 4; k++) begin
            if (wa[k]) ref_mem[int'(aa[k])] = da[k];
            else begin
                ex = ref_rd(aa[k]); n_total++;
                if (ra[k] !== ex) $display("FAIL b2b_rd_a[%0d]: got %h want %h", k, ra[k], ex); else n_pass++;
            end
            if (wb[k]) ref_mem[int'(ab[k])] = db[k];
            else begin
                ex = ref_rd(ab[k]); n_total++;
                if (rb[k] !== ex) $display("FAIL b2b_rd_b[%0d]: got %h want %h", k, rb[k], ex); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_access();
        logic [7:0] rd; int lat; int na, nb; int w;
        // Reset in the bus cycle of a B write.
        do_reset();
        @(posedge clk); #1;
        set_port(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h77);
        w = 0;
        do begin @(negedge clk); w++; end while (!ramChipSelect && w < 10);
        reset = 1'b1; set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        nb = ack_b_cnt;
        @(negedge clk);
        n_total++; if (w >= 10) $display("FAIL rst_wr_bus: bus never active, want active"); else n_pass++;
        n_total++; if ({pb.ack, ramChipSelect, ramWrite} !== 3'b000 || ramAddress !== 16'h0 || pb.rdata !== 8'h0)
            $display("FAIL rst_wr_outs: ack/cs/we=%b addr=%h rdata=%h want 000/0000/00", {pb.ack, ramChipSelect, ramWrite}, ramAddress, pb.rdata);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (ack_b_cnt !== nb) $display("FAIL rst_wr_noack: got %0d acks want %0d", ack_b_cnt, nb); else n_pass++;
        ref_mem[16'hFFFF] = 8'h77;
        @(posedge clk); #1;
        do_port(1'b0, 1'b0, 16'hFFFF, 8'h0, 1'b0, rd, lat);
        n_total++; if (rd !== 8'h77 || lat !== 3) $display("FAIL rst_wr_commit: got %h lat %0d want 77 lat 3", rd, lat); else n_pass++;
        // Reset in the bus cycle of an A read of a nonzero location.
        do_reset();
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h0);
        w = 0;
        do begin @(negedge clk); w++; end while (!ramChipSelect && w < 10);
        reset = 1'b1; set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        na = ack_a_cnt;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (ack_a_cnt !== na) $display("FAIL rst_rd_noack: got %0d acks want %0d", ack_a_cnt, na); else n_pass++;
        n_total++; if (pa.rdata !== 8'h00) $display("FAIL rst_rd_rdata: got %h want 00", pa.rdata); else n_pass++;
    endtask

    task automatic test_boundary();
        logic [7:0] rd, d; int lat;
        logic [15:0] a;
        for (int p = 0; p < 2; p++) begin
            for (int e = 0; e < 2; e++) begin
                a = (e == 0) ? 16'h0000 : 16'hFFFF;
                d = 8'($urandom);
                @(posedge clk); #1;
                do_port(1'(p), 1'b1, a, d, 1'b0, rd, lat);
                ref_mem[int'(a)] = d;
                @(posedge clk); #1;
                do_port(1'(p), 1'b0, a, 8'h0, 1'b0, rd, lat);
                n_total++;
                if (rd !== d || lat !== 3) $display("FAIL boundary_p%0d_%h: got %h lat %0d want %h lat 3", p, a, rd, lat, d);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d, ex; int lat; bit p, w; logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            p = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            a = 16'h0100 + 16'($urandom_range(0, 7)); d = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            ex = ref_rd(a);
            do_port(p, w, a, d, 1'b0, rd, lat);
            n_total++;
            if (lat !== 3) $display("FAIL rand_lat[%0d]: got %0d want 3", i, lat);
            else if (!w && rd !== ex) $display("FAIL rand_rd[%0d]: port %0d addr %h got %h want %h", i, p, a, rd, ex);
            else n_pass++;
            if (w) ref_mem[int'(a)] = d;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_port(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        test_reset();
        test_basic();
        test_tie();
        test_back_to_back();
        test_reset_access();
        test_boundary();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
